// File: rtl/bp_update_ctrl.sv
// bp_update_ctrl: sequencing controller for the gshare predictor's BTB/PHT
// write port.
//
// After reset, or on a clearReq pulse while running, it sweeps every table
// index with clear commands and holds predEnable low until the sweep ends.
// Outside the sweep it buffers EX branch resolutions in a small FIFO and
// issues them one per accepted valid/ready handshake, in push order.
//
// Ports:
//   clk, rst             clock (rising edge) and synchronous active-high reset
//   exBranch/exTaken/    resolved branch from EX (push request and payload)
//   exPc/exTarget
//   exStall              buffer full, EX must hold its branch
//   clearReq             one-cycle full table clear request (honoured in RUN)
//   updValid/updReady    command handshake towards the predictor
//   updInit/updIndex     clear command and its index (index 0 for updates)
//   updPc/updTaken/      branch update payload (FIFO head)
//   updTarget
//   predEnable           fetch predictions allowed
//   busy                 sweeping, or updates still buffered
//
// Optional build macro BP_UPD_STATS_EN adds statUpdates, statStallCycles and
// statClears counters.
module bp_update_ctrl #(
  parameter int BTB_ENTRIES = 128,
  parameter int PHT_ENTRIES = 1024,
  parameter int FIFO_DEPTH  = 4,
  parameter int IDX_W       = $clog2((BTB_ENTRIES > PHT_ENTRIES) ? BTB_ENTRIES : PHT_ENTRIES)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              exBranch,
  input  logic              exTaken,
  input  logic [31:0]       exPc,
  input  logic [31:0]       exTarget,
  output logic              exStall,
  input  logic              clearReq,
  output logic              updValid,
  input  logic              updReady,
  output logic              updInit,
  output logic [IDX_W-1:0]  updIndex,
  output logic [31:0]       updPc,
  output logic              updTaken,
  output logic [31:0]       updTarget,
  output logic              predEnable,
  output logic              busy
`ifdef BP_UPD_STATS_EN
  ,
  output logic [31:0]       statUpdates,
  output logic [31:0]       statStallCycles,
  output logic [15:0]       statClears
`endif
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam logic [IDX_W-1:0] IDX_LAST = {IDX_W{1'b1}};
  localparam logic [IDX_W-1:0] IDX_ONE  = IDX_W'(1);
  localparam logic [PTR_W-1:0] PTR_ONE  = PTR_W'(1);
  localparam logic [PTR_W:0]   OCC_ONE  = (PTR_W + 1)'(1);
  localparam logic [PTR_W:0]   OCC_FULL = (PTR_W + 1)'(FIFO_DEPTH);

  typedef enum logic [0:0] {
    ST_INIT = 1'b0,
    ST_RUN  = 1'b1
  } state_t;

  // Architectural state
  state_t            state_r;
  logic [IDX_W-1:0]  idx_r;
  logic [PTR_W-1:0]  wr_ptr_r;
  logic [PTR_W-1:0]  rd_ptr_r;
  logic [PTR_W:0]    occ_r;

  // Registered outputs
  logic              pred_en_r;
  logic              stall_r;
  logic              valid_r;
  logic              init_r;
  logic [IDX_W-1:0]  index_r;
  logic [31:0]       pc_r;
  logic              taken_r;
  logic [31:0]       target_r;
  logic              busy_r;

  // FIFO storage (no reset needed; occupancy qualifies the contents)
  logic [31:0]           pc_mem     [FIFO_DEPTH];
  logic [31:0]           target_mem [FIFO_DEPTH];
  logic [FIFO_DEPTH-1:0] taken_mem;

  // Handshake / control decode
  logic accept_s;
  logic pop_s;
  logic push_s;
  logic clear_s;

  // Next-state values
  state_t            state_n;
  logic [IDX_W-1:0]  idx_n;
  logic              pred_en_n;
  logic [PTR_W-1:0]  wr_ptr_n;
  logic [PTR_W-1:0]  rd_ptr_n;
  logic [PTR_W:0]    occ_n;
  logic [PTR_W:0]    occ_after_pop_s;
  logic [31:0]       head_pc_s;
  logic              head_taken_s;
  logic [31:0]       head_target_s;
  logic              valid_n;
  logic              init_n;
  logic [IDX_W-1:0]  index_n;
  logic [31:0]       pc_n;
  logic              taken_n;
  logic [31:0]       target_n;

  assign accept_s = valid_r & updReady;
  // Only branch updates pop; clear commands never touch the FIFO.
  assign pop_s    = accept_s & ~init_r;
  assign clear_s  = clearReq & (state_r == ST_RUN);
  // A push is blocked while full and dropped when it coincides with a clear.
  assign push_s   = exBranch & ~stall_r & ~clear_s;

  // Sweep sequencing and state transitions
  always_comb begin
    state_n   = state_r;
    idx_n     = idx_r;
    pred_en_n = pred_en_r;
    case (state_r)
      ST_INIT: begin
        if (accept_s) begin
          if (idx_r == IDX_LAST) begin
            state_n   = ST_RUN;
            idx_n     = '0;
            pred_en_n = 1'b1;
          end else begin
            idx_n = idx_r + IDX_ONE;
          end
        end else begin
          idx_n = idx_r;
        end
      end
      ST_RUN: begin
        if (clear_s) begin
          state_n   = ST_INIT;
          idx_n     = '0;
          pred_en_n = 1'b0;
        end else begin
          state_n = ST_RUN;
        end
      end
      default: begin
        state_n   = ST_INIT;
        idx_n     = '0;
        pred_en_n = 1'b0;
      end
    endcase
  end

  // FIFO pointer and occupancy update
  always_comb begin
    wr_ptr_n = wr_ptr_r;
    rd_ptr_n = rd_ptr_r;
    occ_n    = occ_r;
    if (clear_s) begin
      wr_ptr_n = '0;
      rd_ptr_n = '0;
      occ_n    = '0;
    end else begin
      if (push_s) begin
        wr_ptr_n = wr_ptr_r + PTR_ONE;
      end else begin
        wr_ptr_n = wr_ptr_r;
      end
      if (pop_s) begin
        rd_ptr_n = rd_ptr_r + PTR_ONE;
      end else begin
        rd_ptr_n = rd_ptr_r;
      end
      case ({push_s, pop_s})
        2'b10:   occ_n = occ_r + OCC_ONE;
        2'b01:   occ_n = occ_r - OCC_ONE;
        default: occ_n = occ_r;
      endcase
    end
  end

  // Next head of FIFO: if it drains to empty this cycle, the entry being
  // written now becomes the head and is loaded straight into the output
  // register (the array write lands on the same edge).
  always_comb begin
    occ_after_pop_s = pop_s ? (occ_r - OCC_ONE) : occ_r;
    if (occ_after_pop_s == '0) begin
      head_pc_s     = exPc;
      head_taken_s  = exTaken;
      head_target_s = exTarget;
    end else begin
      head_pc_s     = pc_mem[rd_ptr_n];
      head_taken_s  = taken_mem[rd_ptr_n];
      head_target_s = target_mem[rd_ptr_n];
    end
  end

  // Output command selection for the next cycle
  always_comb begin
    valid_n  = 1'b0;
    init_n   = 1'b0;
    index_n  = '0;
    pc_n     = 32'h0000_0000;
    taken_n  = 1'b0;
    target_n = 32'h0000_0000;
    if (state_n == ST_INIT) begin
      valid_n = 1'b1;
      init_n  = 1'b1;
      index_n = idx_n;
    end else begin
      valid_n  = (occ_n != '0);
      pc_n     = head_pc_s;
      taken_n  = head_taken_s;
      target_n = head_target_s;
    end
  end

  // FIFO storage write
  always_ff @(posedge clk) begin
    if (push_s) begin
      pc_mem[wr_ptr_r]     <= exPc;
      taken_mem[wr_ptr_r]  <= exTaken;
      target_mem[wr_ptr_r] <= exTarget;
    end
  end

  // State and registered-output update
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r   <= ST_INIT;
      idx_r     <= '0;
      wr_ptr_r  <= '0;
      rd_ptr_r  <= '0;
      occ_r     <= '0;
      pred_en_r <= 1'b0;
      stall_r   <= 1'b0;
      valid_r   <= 1'b0;
      init_r    <= 1'b0;
      index_r   <= '0;
      pc_r      <= 32'h0000_0000;
      taken_r   <= 1'b0;
      target_r  <= 32'h0000_0000;
      busy_r    <= 1'b1;
    end else begin
      state_r   <= state_n;
      idx_r     <= idx_n;
      wr_ptr_r  <= wr_ptr_n;
      rd_ptr_r  <= rd_ptr_n;
      occ_r     <= occ_n;
      pred_en_r <= pred_en_n;
      stall_r   <= (occ_n == OCC_FULL);
      valid_r   <= valid_n;
      init_r    <= init_n;
      index_r   <= index_n;
      pc_r      <= pc_n;
      taken_r   <= taken_n;
      target_r  <= target_n;
      busy_r    <= (state_n == ST_INIT) | (occ_n != '0);
    end
  end

  assign exStall    = stall_r;
  assign updValid   = valid_r;
  assign updInit    = init_r;
  assign updIndex   = index_r;
  assign updPc      = pc_r;
  assign updTaken   = taken_r;
  assign updTarget  = target_r;
  assign predEnable = pred_en_r;
  assign busy       = busy_r;

`ifdef BP_UPD_STATS_EN
  logic [31:0] stat_upd_r;
  logic [31:0] stat_stall_r;
  logic [15:0] stat_clr_r;

  // Statistics counters; they wrap and survive clearReq
  always_ff @(posedge clk) begin
    if (rst) begin
      stat_upd_r   <= 32'd0;
      stat_stall_r <= 32'd0;
      stat_clr_r   <= 16'd0;
    end else begin
      if (pop_s) begin
        stat_upd_r <= stat_upd_r + 32'd1;
      end
      if (exBranch & stall_r) begin
        stat_stall_r <= stat_stall_r + 32'd1;
      end
      if (clear_s) begin
        stat_clr_r <= stat_clr_r + 16'd1;
      end
    end
  end

  assign statUpdates     = stat_upd_r;
  assign statStallCycles = stat_stall_r;
  assign statClears      = stat_clr_r;
`endif

endmodule

// File: tb/tb_bp_update_ctrl.sv
// Directed self-checking bench for bp_update_ctrl (default parameters,
// 1024-entry sweep, 4-deep update FIFO).
module tb_bp_update_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        exBranch;
  logic        exTaken;
  logic [31:0] exPc;
  logic [31:0] exTarget;
  logic        exStall;
  logic        clearReq;
  logic        updValid;
  logic        updReady;
  logic        updInit;
  logic [9:0]  updIndex;
  logic [31:0] updPc;
  logic        updTaken;
  logic [31:0] updTarget;
  logic        predEnable;
  logic        busy;
`ifdef BP_UPD_STATS_EN
  logic [31:0] statUpdates;
  logic [31:0] statStallCycles;
  logic [15:0] statClears;
`endif

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  bp_update_ctrl dut (
    .clk(clk),
    .rst(rst),
    .exBranch(exBranch),
    .exTaken(exTaken),
    .exPc(exPc),
    .exTarget(exTarget),
    .exStall(exStall),
    .clearReq(clearReq),
    .updValid(updValid),
    .updReady(updReady),
    .updInit(updInit),
    .updIndex(updIndex),
    .updPc(updPc),
    .updTaken(updTaken),
    .updTarget(updTarget),
    .predEnable(predEnable),
    .busy(busy)
`ifdef BP_UPD_STATS_EN
    ,
    .statUpdates(statUpdates),
    .statStallCycles(statStallCycles),
    .statClears(statClears)
`endif
  );

  task automatic check32(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic check1(input string tag, input logic obs, input logic exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %b expected %b", tag, obs, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic drive_branch(input logic [31:0] pc, input logic tk, input logic [31:0] tgt);
    exBranch = 1'b1;
    exPc     = pc;
    exTaken  = tk;
    exTarget = tgt;
  endtask

  initial begin
    int e;
    int c;
    logic [31:0] pc_v;
    logic [31:0] tgt_v;
    logic        tk_v;

    rst      = 1'b1;
    exBranch = 1'b0;
    exTaken  = 1'b0;
    exPc     = 32'h0;
    exTarget = 32'h0;
    clearReq = 1'b0;
    updReady = 1'b1;
    tick;
    tick;

    // Reset values
    check1("rst_valid", updValid, 1'b0);
    check1("rst_pred", predEnable, 1'b0);
    check1("rst_stall", exStall, 1'b0);
    check1("rst_busy", busy, 1'b1);
    rst = 1'b0;

    // Full sweep with updReady tied high
    for (int i = 0; i < 1024; i++) begin
      tick;
      check1("sweep_valid", updValid, 1'b1);
      check1("sweep_init", updInit, 1'b1);
      check32("sweep_idx", {22'd0, updIndex}, 32'(i));
      check1("sweep_pred", predEnable, 1'b0);
    end
    tick;
    check1("run_pred", predEnable, 1'b1);
    check1("run_valid_empty", updValid, 1'b0);
    check1("run_busy", busy, 1'b0);

    // Single branch into empty FIFO: visible one cycle later
    drive_branch(32'h0000_1004, 1'b1, 32'h0000_2000);
    tick;
    exBranch = 1'b0;
    check1("one_valid", updValid, 1'b1);
    check1("one_init", updInit, 1'b0);
    check32("one_idx", {22'd0, updIndex}, 32'd0);
    check32("one_pc", updPc, 32'h0000_1004);
    check1("one_taken", updTaken, 1'b1);
    check32("one_tgt", updTarget, 32'h0000_2000);
    tick;
    check1("one_drained", updValid, 1'b0);

    // Back-pressure: 5 pushes with updReady low, only 4 accepted
    updReady = 1'b0;
    for (int k = 0; k < 5; k++) begin
      drive_branch(32'h0000_0100 + 32'(k * 4), k[0], 32'h0000_2000 + 32'(k * 16));
      tick;
      check1("fill_stall", exStall, (k >= 3) ? 1'b1 : 1'b0);
      check32("fill_head_pc", updPc, 32'h0000_0100);
    end
    // EX keeps re-presenting 0x110; the first drain edge must still refuse it
    updReady = 1'b1;
    tick;
    check1("drain_stall_drop", exStall, 1'b0);
    check32("drain_pc0", updPc, 32'h0000_0104);
    tick;
    exBranch = 1'b0;
    for (int j = 2; j < 5; j++) begin
      pc_v  = 32'h0000_0100 + 32'(j * 4);
      tgt_v = 32'h0000_2000 + 32'(j * 16);
      tk_v  = (j % 2) == 1;
      check1("drain_valid", updValid, 1'b1);
      check32("drain_pc", updPc, pc_v);
      check1("drain_taken", updTaken, tk_v);
      check32("drain_tgt", updTarget, tgt_v);
      tick;
    end
    check1("drain_empty", updValid, 1'b0);

    // Clear in RUN with 3 queued entries and a same-cycle push
    updReady = 1'b0;
    for (int k = 0; k < 3; k++) begin
      drive_branch(32'h0000_0300 + 32'(k * 4), 1'b1, 32'h0000_3000);
      tick;
    end
    check32("q3_head", updPc, 32'h0000_0300);
    drive_branch(32'h0000_030C, 1'b1, 32'h0000_3000);
    clearReq = 1'b1;
    tick;
    clearReq = 1'b0;
    exBranch = 1'b0;
    check1("clr_valid", updValid, 1'b1);
    check1("clr_init", updInit, 1'b1);
    check32("clr_idx", {22'd0, updIndex}, 32'd0);
    check1("clr_pred", predEnable, 1'b0);
    check1("clr_stall", exStall, 1'b0);
    check1("clr_busy", busy, 1'b1);

    // Sweep with updReady toggling, 2 pushes, and an ignored clear at index 500
    e = 0;
    c = 0;
    while (e < 1024 && c < 4000) begin
      check1("tog_valid", updValid, 1'b1);
      check1("tog_init", updInit, 1'b1);
      check32("tog_idx", {22'd0, updIndex}, 32'(e));
      check1("tog_pred", predEnable, 1'b0);
      updReady = (c % 2) == 0;
      exBranch = 1'b0;
      if (c == 10) drive_branch(32'h0000_0500, 1'b0, 32'h0000_5000);
      if (c == 11) drive_branch(32'h0000_0504, 1'b1, 32'h0000_5040);
      clearReq = (c == 1000);
      if (c == 1000) check32("tog_clr_idx", {22'd0, updIndex}, 32'd500);
      tick;
      if (updReady) e++;
      c++;
    end
    exBranch = 1'b0;
    clearReq = 1'b0;
    updReady = 1'b0;
    check1("tog_bound", (c < 4000), 1'b1);
    check32("tog_cycles", 32'(c), 32'd2047);
    check1("tog_run_pred", predEnable, 1'b1);
    check1("tog_run_valid", updValid, 1'b1);
    check1("tog_run_init", updInit, 1'b0);
    check32("tog_first_pc", updPc, 32'h0000_0500);
    check1("tog_first_taken", updTaken, 1'b0);
    check32("tog_first_tgt", updTarget, 32'h0000_5000);
    updReady = 1'b1;
    tick;
    check32("tog_second_pc", updPc, 32'h0000_0504);
    check1("tog_second_taken", updTaken, 1'b1);
    check32("tog_second_tgt", updTarget, 32'h0000_5040);
    tick;
    check1("tog_empty", updValid, 1'b0);
    check1("tog_idle", busy, 1'b0);

`ifdef BP_UPD_STATS_EN
    check32("stat_upd", statUpdates, 32'd8);
    check32("stat_stall", statStallCycles, 32'd2);
    check32("stat_clr", {16'd0, statClears}, 32'd1);
`endif

    // Reset mid-operation with buffered entries
    updReady = 1'b0;
    drive_branch(32'h0000_0700, 1'b1, 32'h0000_7000);
    tick;
    drive_branch(32'h0000_0704, 1'b1, 32'h0000_7000);
    tick;
    exBranch = 1'b0;
    check1("pre_rst_valid", updValid, 1'b1);
    rst = 1'b1;
    tick;
    rst = 1'b0;
    check1("mid_rst_valid", updValid, 1'b0);
    check1("mid_rst_pred", predEnable, 1'b0);
    check1("mid_rst_stall", exStall, 1'b0);
`ifdef BP_UPD_STATS_EN
    check32("mid_rst_stat_upd", statUpdates, 32'd0);
    check32("mid_rst_stat_stall", statStallCycles, 32'd0);
    check32("mid_rst_stat_clr", {16'd0, statClears}, 32'd0);
`endif
    tick;
    check1("restart_valid", updValid, 1'b1);
    check1("restart_init", updInit, 1'b1);
    check32("restart_idx", {22'd0, updIndex}, 32'd0);
    updReady = 1'b1;
    tick;
    check32("restart_idx1", {22'd0, updIndex}, 32'd1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
